// File: rtl/i2c_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : i2c_master_arbiter
// Function : Round-robin share of one i2c_master engine between two
//            requesters. Each grant runs one complete register transaction,
//            captures read data and status into the winning port, and
//            recovers from a hung bus through a cycle timeout.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_master_arbiter #(
  parameter int NUM_ADDR_BYTES = 2,
  parameter int NUM_DATA_BYTES = 1,
  parameter int REG_ADDR_WIDTH = 16,
  parameter int TIMEOUT_CYCLES = 1048575
) (
  input  logic                                   ifclk,
  input  logic                                   reset,
  // requester 0
  input  logic                                   rq0_req,
  input  logic                                   rq0_rnw,
  input  logic [6:0]                             rq0_chip_addr,
  input  logic [REG_ADDR_WIDTH-1:0]              rq0_reg_addr,
  input  logic [8*NUM_DATA_BYTES-1:0]            rq0_datai,
  output logic                                   rq0_ack,
  output logic [8*NUM_DATA_BYTES-1:0]            rq0_datao,
  output logic [15:0]                            rq0_status,
  // requester 1
  input  logic                                   rq1_req,
  input  logic                                   rq1_rnw,
  input  logic [6:0]                             rq1_chip_addr,
  input  logic [REG_ADDR_WIDTH-1:0]              rq1_reg_addr,
  input  logic [8*NUM_DATA_BYTES-1:0]            rq1_datai,
  output logic                                   rq1_ack,
  output logic [8*NUM_DATA_BYTES-1:0]            rq1_datao,
  output logic [15:0]                            rq1_status,
  // ownership
  output logic [1:0]                             grant,
  // shared master command / status
  output logic [6:0]                             m_chip_addr,
  output logic [REG_ADDR_WIDTH-1:0]              m_reg_addr,
  output logic [8*NUM_DATA_BYTES-1:0]            m_datai,
  output logic                                   m_we,
  output logic                                   m_re,
  output logic                                   m_write_mode,
  input  logic                                   m_busy,
  input  logic                                   m_done,
  input  logic [NUM_ADDR_BYTES+NUM_DATA_BYTES:0] m_status,
  input  logic [8*NUM_DATA_BYTES-1:0]            m_datao
);

  localparam int          c_DATA_W       = 8 * NUM_DATA_BYTES;
  localparam logic [19:0] c_TIMEOUT_LAST = 20'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_COMPLETE  = 2'd3
  } state_t;

  state_t                    r_state, w_state;
  logic                      r_last, w_last;
  logic                      r_rnw, w_rnw;
  logic [19:0]               r_timer, w_timer;

  logic [1:0]                w_grant, w_ack;
  logic                      w_m_we, w_m_re, w_m_write_mode;
  logic [6:0]                w_chip;
  logic [REG_ADDR_WIDTH-1:0] w_reg;
  logic [c_DATA_W-1:0]       w_datai;
  logic [15:0]               w_status0, w_status1;
  logic [c_DATA_W-1:0]       w_datao0, w_datao1;

  logic                      w_sel;
  logic                      w_timeout;

  // Winner index: on a tie the port that was not served last wins.
  assign w_sel     = (rq0_req && rq1_req) ? ~r_last : rq1_req;
  assign w_timeout = (r_timer == c_TIMEOUT_LAST);

  // Next-state and next-output computation; every output is registered below.
  always_comb begin
    w_state        = r_state;
    w_last         = r_last;
    w_rnw          = r_rnw;
    w_timer        = r_timer;
    w_grant        = grant;
    w_ack          = 2'b00;
    w_m_we         = 1'b0;
    w_m_re         = 1'b0;
    w_m_write_mode = m_write_mode;
    w_chip         = m_chip_addr;
    w_reg          = m_reg_addr;
    w_datai        = m_datai;
    w_status0      = rq0_status;
    w_status1      = rq1_status;
    w_datao0       = rq0_datao;
    w_datao1       = rq1_datao;

    case (r_state)
      S_IDLE: begin
        if (!m_busy && (rq0_req || rq1_req)) begin
          w_grant        = w_sel ? 2'b10 : 2'b01;
          w_rnw          = w_sel ? rq1_rnw       : rq0_rnw;
          w_chip         = w_sel ? rq1_chip_addr : rq0_chip_addr;
          w_reg          = w_sel ? rq1_reg_addr  : rq0_reg_addr;
          w_datai        = w_sel ? rq1_datai     : rq0_datai;
          // Strobe is registered so it is high during the ISSUE cycle.
          w_m_re         = w_rnw;
          w_m_we         = ~w_rnw;
          w_m_write_mode = ~w_rnw;
          w_state        = S_ISSUE;
        end
      end

      S_ISSUE: begin
        w_timer = 20'd0;
        w_state = S_WAIT_DONE;
      end

      S_WAIT_DONE: begin
        // m_done takes priority over a coincident timeout.
        if (m_done || w_timeout) begin
          w_ack   = grant;
          w_state = S_COMPLETE;
          if (grant[1]) begin
            w_status1 = m_done ? 16'(m_status) : 16'h8000;
            if (m_done && r_rnw) begin
              w_datao1 = m_datao;
            end
          end else begin
            w_status0 = m_done ? 16'(m_status) : 16'h8000;
            if (m_done && r_rnw) begin
              w_datao0 = m_datao;
            end
          end
        end else begin
          w_timer = r_timer + 20'd1;
        end
      end

      S_COMPLETE: begin
        w_last         = grant[1];
        w_grant        = 2'b00;
        w_m_write_mode = 1'b0;
        w_state        = S_IDLE;
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge ifclk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_last       <= 1'b1;
      r_rnw        <= 1'b0;
      r_timer      <= 20'd0;
      grant        <= 2'b00;
      rq0_ack      <= 1'b0;
      rq1_ack      <= 1'b0;
      m_we         <= 1'b0;
      m_re         <= 1'b0;
      m_write_mode <= 1'b0;
      m_chip_addr  <= '0;
      m_reg_addr   <= '0;
      m_datai      <= '0;
      rq0_status   <= 16'h0000;
      rq1_status   <= 16'h0000;
      rq0_datao    <= '0;
      rq1_datao    <= '0;
    end else begin
      r_state      <= w_state;
      r_last       <= w_last;
      r_rnw        <= w_rnw;
      r_timer      <= w_timer;
      grant        <= w_grant;
      rq0_ack      <= w_ack[0];
      rq1_ack      <= w_ack[1];
      m_we         <= w_m_we;
      m_re         <= w_m_re;
      m_write_mode <= w_m_write_mode;
      m_chip_addr  <= w_chip;
      m_reg_addr   <= w_reg;
      m_datai      <= w_datai;
      rq0_status   <= w_status0;
      rq1_status   <= w_status1;
      rq0_datao    <= w_datao0;
      rq1_datao    <= w_datao1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_master_arbiter
// Function : Self-checking bench for i2c_master_arbiter with a behavioural
//            master model, two requester drivers and a transaction-level
//            reference of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_master_arbiter;

  localparam int c_T = 100;

  logic        ifclk = 1'b0;
  logic        reset = 1'b1;

  logic        rq0_req, rq0_rnw, rq1_req, rq1_rnw;
  logic [6:0]  rq0_chip_addr, rq1_chip_addr;
  logic [15:0] rq0_reg_addr, rq1_reg_addr;
  logic [7:0]  rq0_datai, rq1_datai;
  logic        rq0_ack, rq1_ack;
  logic [7:0]  rq0_datao, rq1_datao;
  logic [15:0] rq0_status, rq1_status;
  logic [1:0]  grant;
  logic [6:0]  m_chip_addr;
  logic [15:0] m_reg_addr;
  logic [7:0]  m_datai;
  logic        m_we, m_re, m_write_mode;
  logic        m_busy, m_done;
  logic [3:0]  m_status;
  logic [7:0]  m_datao;

  i2c_master_arbiter #(
    .NUM_ADDR_BYTES(2), .NUM_DATA_BYTES(1), .REG_ADDR_WIDTH(16), .TIMEOUT_CYCLES(c_T)
  ) u_dut (
    .ifclk(ifclk), .reset(reset),
    .rq0_req(rq0_req), .rq0_rnw(rq0_rnw), .rq0_chip_addr(rq0_chip_addr),
    .rq0_reg_addr(rq0_reg_addr), .rq0_datai(rq0_datai), .rq0_ack(rq0_ack),
    .rq0_datao(rq0_datao), .rq0_status(rq0_status),
    .rq1_req(rq1_req), .rq1_rnw(rq1_rnw), .rq1_chip_addr(rq1_chip_addr),
    .rq1_reg_addr(rq1_reg_addr), .rq1_datai(rq1_datai), .rq1_ack(rq1_ack),
    .rq1_datao(rq1_datao), .rq1_status(rq1_status),
    .grant(grant),
    .m_chip_addr(m_chip_addr), .m_reg_addr(m_reg_addr), .m_datai(m_datai),
    .m_we(m_we), .m_re(m_re), .m_write_mode(m_write_mode),
    .m_busy(m_busy), .m_done(m_done), .m_status(m_status), .m_datao(m_datao)
  );

  always #5 ifclk = ~ifclk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // requester bookkeeping and inputs seen at the upcoming edge
  bit          act [2];
  bit          p_req [2];
  bit          p_rnw [2];
  logic [6:0]  p_chip [2];
  logic [15:0] p_reg [2];
  logic [7:0]  p_dat [2];
  bit          p_busy;

  // reference arbiter
  int          ref_owner = -1;
  bit          rel_pend  = 1'b0;
  bit          ref_last  = 1'b1;
  int          idle_since = 0;
  bit          ref_rnw;
  logic [6:0]  ref_chip;
  logic [15:0] ref_reg;
  logic [7:0]  ref_dat;
  logic [15:0] ref_status [2];
  logic [7:0]  ref_datao [2];
  int          strobe_t = -1000;
  int          ack_t    = -1000;
  int          done_t   = -1;
  logic [3:0]  done_st;
  logic [7:0]  done_dat;
  int          glog [$];

  // master model
  bit          mm_active = 1'b0;
  bit          mm_hang;
  int          mm_done_t;
  logic [3:0]  mm_st;
  logic [7:0]  mm_dat;
  logic [30:0] mm_cmd;
  bit          mm_rd;
  bit          bg_busy = 1'b0;
  bit          dir_valid = 1'b0;
  bit          dir_hang;
  int          dir_lat;
  logic [3:0]  dir_st;
  logic [7:0]  dir_dat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic set_fields(input int p, input bit rnw, input logic [6:0] ch,
                            input logic [15:0] rg, input logic [7:0] d);
    if (p == 0) begin
      rq0_rnw = rnw; rq0_chip_addr = ch; rq0_reg_addr = rg; rq0_datai = d;
    end else begin
      rq1_rnw = rnw; rq1_chip_addr = ch; rq1_reg_addr = rg; rq1_datai = d;
    end
  endtask

  task automatic issue(input int p, input bit rnw, input logic [6:0] ch,
                       input logic [15:0] rg, input logic [7:0] d);
    set_fields(p, rnw, ch, rg, d);
    if (p == 0) rq0_req = 1'b1; else rq1_req = 1'b1;
    act[p] = 1'b1;
  endtask

  task automatic issue_rand(input int p);
    issue(p, 1'($urandom), 7'($urandom), 16'($urandom), 8'($urandom));
  endtask

  task automatic direct(input int lat, input bit hang, input logic [3:0] st, input logic [7:0] d);
    dir_valid = 1'b1; dir_lat = lat; dir_hang = hang; dir_st = st; dir_dat = d;
  endtask

  // One clock cycle: predict, compare, then drive master and requesters.
  task automatic tick();
    logic [1:0] e_grant, e_ack;
    bit         e_we, e_re, e_wm;
    int         o;
    p_req[0] = rq0_req; p_rnw[0] = rq0_rnw; p_chip[0] = rq0_chip_addr;
    p_reg[0] = rq0_reg_addr; p_dat[0] = rq0_datai;
    p_req[1] = rq1_req; p_rnw[1] = rq1_rnw; p_chip[1] = rq1_chip_addr;
    p_reg[1] = rq1_reg_addr; p_dat[1] = rq1_datai;
    p_busy   = m_busy;
    @(posedge ifclk);
    #1;
    cyc++;
    e_we = 1'b0; e_re = 1'b0; e_ack = 2'b00;
    if (rel_pend) begin
      ref_owner = -1; idle_since = cyc; rel_pend = 1'b0;
    end
    if (ref_owner < 0 && cyc - 1 >= idle_since && !p_busy && (p_req[0] || p_req[1])) begin
      if (p_req[0] && p_req[1]) o = ref_last ? 0 : 1;
      else                      o = p_req[1] ? 1 : 0;
      ref_owner = o;
      ref_rnw = p_rnw[o]; ref_chip = p_chip[o]; ref_reg = p_reg[o]; ref_dat = p_dat[o];
      strobe_t = cyc; done_t = -1;
      e_we = !ref_rnw; e_re = ref_rnw;
      glog.push_back(o);
    end
    if (ref_owner >= 0 && !rel_pend && cyc > strobe_t) begin
      if ((done_t >= 0 && cyc == done_t + 1 && done_t <= strobe_t + c_T) ||
          (done_t < 0 && cyc == strobe_t + c_T + 1)) begin
        o = ref_owner;
        e_ack[o] = 1'b1;
        if (done_t >= 0) begin
          ref_status[o] = {12'h000, done_st};
          if (ref_rnw) ref_datao[o] = done_dat;
        end else begin
          ref_status[o] = 16'h8000;
        end
        ref_last = (o == 1);
        rel_pend = 1'b1;
        ack_t    = cyc;
      end
    end
    e_grant = (ref_owner < 0) ? 2'b00 : ((ref_owner == 1) ? 2'b10 : 2'b01);
    e_wm    = (ref_owner >= 0) && !ref_rnw;

    chk("grant", 64'(grant), 64'(e_grant));
    chk("m_we", 64'(m_we), 64'(e_we));
    chk("m_re", 64'(m_re), 64'(e_re));
    chk("write_mode", 64'(m_write_mode), 64'(e_wm));
    chk("m_cmd", 64'({m_chip_addr, m_reg_addr, m_datai}), 64'({ref_chip, ref_reg, ref_dat}));
    chk("ack", 64'({rq1_ack, rq0_ack}), 64'(e_ack));
    chk("rq0_status", 64'(rq0_status), 64'(ref_status[0]));
    chk("rq1_status", 64'(rq1_status), 64'(ref_status[1]));
    chk("rq0_datao", 64'(rq0_datao), 64'(ref_datao[0]));
    chk("rq1_datao", 64'(rq1_datao), 64'(ref_datao[1]));

    // master engine: status/data are junk except alongside m_done
    m_done   = 1'b0;
    m_status = 4'($urandom);
    m_datao  = 8'($urandom);
    if (m_we || m_re) begin
      mm_active = 1'b1; m_busy = 1'b1;
      mm_cmd = {m_chip_addr, m_reg_addr, m_datai}; mm_rd = m_re;
      if (dir_valid) begin
        mm_hang = dir_hang; mm_st = dir_st; mm_dat = dir_dat; mm_done_t = cyc + dir_lat;
        dir_valid = 1'b0;
      end else begin
        mm_hang = 1'b0;
        mm_st   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
        mm_dat  = 8'($urandom);
        mm_done_t = cyc + int'($urandom_range(1, 12));
      end
    end else if (mm_active) begin
      if (!mm_hang && cyc == mm_done_t) begin
        m_done = 1'b1; m_status = mm_st; m_datao = mm_dat;
        m_busy = 1'b0; mm_active = 1'b0;
        if (ref_owner >= 0 && !rel_pend) begin
          done_t = cyc; done_st = mm_st; done_dat = mm_dat;
        end
      end else if (mm_hang && (rq0_ack || rq1_ack)) begin
        m_busy = 1'b0; mm_active = 1'b0;
      end
    end else begin
      m_busy = bg_busy && ($urandom_range(0, 7) == 0);
    end

    // requesters: drop on ack, wiggle fields while owning the master
    if (rq0_ack) begin
      rq0_req = 1'b0; act[0] = 1'b0;
    end else if (act[0] && grant[0]) begin
      set_fields(0, 1'($urandom), 7'($urandom), 16'($urandom), 8'($urandom));
    end
    if (rq1_ack) begin
      rq1_req = 1'b0; act[1] = 1'b0;
    end else if (act[1] && grant[1]) begin
      set_fields(1, 1'($urandom), 7'($urandom), 16'($urandom), 8'($urandom));
    end
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_strobes", 64'({m_we, m_re, m_write_mode, rq1_ack, rq0_ack}), 64'(0));
    chk("rst_status", 64'({rq1_status, rq0_status}), 64'(0));
    chk("rst_datao", 64'({rq1_datao, rq0_datao}), 64'(0));
    chk("rst_cmd", 64'({m_chip_addr, m_reg_addr, m_datai}), 64'(0));
    ref_owner = -1; rel_pend = 1'b0; ref_last = 1'b1; done_t = -1;
    ref_rnw = 1'b0; ref_chip = '0; ref_reg = '0; ref_dat = '0;
    ref_status[0] = '0; ref_status[1] = '0; ref_datao[0] = '0; ref_datao[1] = '0;
    mm_active = 1'b0; m_busy = 1'b0; m_done = 1'b0; dir_valid = 1'b0;
    repeat (2) begin
      @(posedge ifclk);
      cyc++;
    end
    #3;
    reset = 1'b0;
    idle_since = cyc;
  endtask

  task automatic wait_quiet(input int budget);
    int n;
    n = 0;
    while ((act[0] || act[1] || ref_owner >= 0 || rel_pend || mm_active) && n < budget) begin
      tick();
      n++;
    end
    chk("quiet_within_budget", 64'(n < budget), 64'(1));
  endtask

  initial begin
    int base, issued, n;
    rq0_req = 1'b0; rq1_req = 1'b0;
    set_fields(0, 1'b0, '0, '0, '0);
    set_fields(1, 1'b0, '0, '0, '0);
    act[0] = 1'b0; act[1] = 1'b0;
    m_busy = 1'b0; m_done = 1'b0; m_status = '0; m_datao = '0;
    do_reset();

    // single write, port 0
    direct(40, 1'b0, 4'h0, 8'h00);
    issue(0, 1'b0, 7'h48, 16'h0012, 8'hA5);
    wait_quiet(200);
    chk("wr_cmd", 64'(mm_cmd), 64'({7'h48, 16'h0012, 8'hA5}));
    chk("wr_ack_latency", 64'(ack_t - strobe_t), 64'(41));
    chk("wr_status", 64'(rq0_status), 64'(0));

    // single read, port 1
    direct(10, 1'b0, 4'h0, 8'h3C);
    issue(1, 1'b1, 7'h21, 16'h0100, 8'h00);
    wait_quiet(200);
    chk("rd_is_read", 64'(mm_rd), 64'(1));
    chk("rd_data", 64'(rq1_datao), 64'(8'h3C));

    // NACK
    direct(6, 1'b0, 4'b0010, 8'h00);
    issue(0, 1'b0, 7'h10, 16'h0203, 8'h77);
    wait_quiet(200);
    chk("nack_status", 64'(rq0_status), 64'(16'h0002));

    // timeout on a read, then a good read clears status
    direct(0, 1'b1, 4'h0, 8'h00);
    issue(1, 1'b1, 7'h33, 16'h0404, 8'h00);
    wait_quiet(300);
    chk("to_latency", 64'(ack_t - strobe_t), 64'(c_T + 1));
    chk("to_status", 64'(rq1_status), 64'(16'h8000));
    chk("to_data_kept", 64'(rq1_datao), 64'(8'h3C));
    direct(5, 1'b0, 4'h0, 8'h5A);
    issue(1, 1'b1, 7'h33, 16'h0404, 8'h00);
    wait_quiet(200);
    chk("after_to_status", 64'(rq1_status), 64'(0));
    chk("after_to_data", 64'(rq1_datao), 64'(8'h5A));

    // m_done on the very last timeout cycle wins
    direct(c_T, 1'b0, 4'b0100, 8'h00);
    issue(0, 1'b0, 7'h55, 16'h0505, 8'h12);
    wait_quiet(300);
    chk("coinc_latency", 64'(ack_t - strobe_t), 64'(c_T + 1));
    chk("coinc_status", 64'(rq0_status), 64'(16'h0004));

    // both held from reset: four alternating grants
    do_reset();
    base = glog.size();
    issue_rand(0); issue_rand(1); issued = 2; n = 0;
    while ((act[0] || act[1] || ref_owner >= 0 || rel_pend) && n < 400) begin
      tick();
      n++;
      for (int p = 0; p < 2; p++) begin
        if (!act[p] && issued < 4) begin
          issue_rand(p);
          issued++;
        end
      end
    end
    chk("alt_within_budget", 64'(n < 400), 64'(1));
    for (int i = 0; i < 4; i++) begin
      chk("alt_order", 64'((glog.size() > base + i) ? glog[base + i] : 9), 64'(i % 2));
    end
    wait_quiet(200);

    // reset in WAIT_DONE with both requests held
    direct(40, 1'b0, 4'h0, 8'h00);
    issue_rand(0); issue_rand(1);
    n = 0;
    while (!(m_we || m_re) && n < 50) begin
      tick();
      n++;
    end
    chk("rst_setup_strobe", 64'(m_we | m_re), 64'(1));
    repeat (5) tick();
    do_reset();
    base = glog.size();
    wait_quiet(300);
    chk("rst_regrant_port", 64'((glog.size() > base) ? glog[base] : 9), 64'(0));

    // randomized traffic with background master busy
    bg_busy = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      for (int p = 0; p < 2; p++) begin
        if (!act[p] && $urandom_range(0, 4) == 0) issue_rand(p);
      end
    end
    bg_busy = 1'b0;
    wait_quiet(500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
